// File: rtl/mem_arbiter.sv
// Byte-serial memory arbiter: multiplexes instruction fetch and data load/store
// onto a single 8-bit RAM/IO port, one byte per cycle, assembling W-bit words.
module mem_arbiter #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    MAX_BYTES  = 4,
    parameter logic [ADDR_WIDTH-1:0] IO_BASE    = 32'h0003_0000,
    parameter int                    NB_WIDTH   = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rdy,
    input  logic [ADDR_WIDTH-1:0]   if_addr,
    input  logic                    if_request,
    input  logic                    if_flush,
    output logic [8*MAX_BYTES-1:0]  if_inst,
    output logic                    if_done,
    input  logic [ADDR_WIDTH-1:0]   mem_addr,
    input  logic                    load_req,
    input  logic                    store_req,
    input  logic [NB_WIDTH-1:0]     num_of_bytes,
    input  logic                    load_signed,
    input  logic [8*MAX_BYTES-1:0]  store_data,
    output logic [8*MAX_BYTES-1:0]  load_data,
    output logic                    mem_done,
    input  logic                    io_buffer_full,
    input  logic [7:0]              mem_din,
    output logic [7:0]              mem_dout,
    output logic [ADDR_WIDTH-1:0]   mem_a,
    output logic                    mem_wr
);

    localparam int W = 8 * MAX_BYTES;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_IF_RD = 2'd1;
    localparam logic [1:0] S_LD_RD = 2'd2;
    localparam logic [1:0] S_ST_WR = 2'd3;

    localparam logic [NB_WIDTH-1:0] NB_MAX  = NB_WIDTH'(MAX_BYTES);
    localparam logic [NB_WIDTH-1:0] NB_ONE  = NB_WIDTH'(1);
    localparam logic [NB_WIDTH-1:0] NB_ZERO = NB_WIDTH'(0);

    logic [1:0]            state_r;
    logic [NB_WIDTH-1:0]   cnt_r;
    logic [NB_WIDTH-1:0]   nb_r;
    logic [ADDR_WIDTH-1:0] addr_r;
    logic                  sign_r;
    logic [W-1:0]          wdata_r;
    logic [W-1:0]          buf_r;
    logic [W-1:0]          if_inst_r;
    logic [W-1:0]          load_data_r;
    logic                  if_done_r;
    logic                  mem_done_r;

    logic [NB_WIDTH-1:0]   nb_eff_s;
    logic                  io_addr_s;
    logic                  ld_go_s;
    logic                  st_go_s;
    logic                  if_go_s;
    logic [W-1:0]          word_s;
    logic [W-1:0]          wshift_s;
    logic [ADDR_WIDTH-1:0] mem_a_s;
    logic [7:0]            mem_dout_s;
    logic                  mem_wr_s;

    // Illegal byte counts (0 or above MAX_BYTES) collapse to a full word.
    always_comb begin
        if ((num_of_bytes == NB_ZERO) || (num_of_bytes > NB_MAX)) begin
            nb_eff_s = NB_MAX;
        end else begin
            nb_eff_s = num_of_bytes;
        end
    end

    // Idle arbitration: load, then store (unless IO sink is full), then fetch.
    always_comb begin
        io_addr_s = (mem_addr >= IO_BASE);
        ld_go_s   = 1'b0;
        st_go_s   = 1'b0;
        if_go_s   = 1'b0;
        if (!rst && rdy && (state_r == S_IDLE)) begin
            if (load_req) begin
                ld_go_s = 1'b1;
            end else if (store_req && !(io_addr_s && io_buffer_full)) begin
                st_go_s = 1'b1;
            end else if (if_request && !if_flush) begin
                if_go_s = 1'b1;
            end else begin
                if_go_s = 1'b0;
            end
        end else begin
            ld_go_s = 1'b0;
        end
    end

    // Merge the byte arriving now into the buffer; bytes above the length get
    // the fill, whose sign comes from mem_din because the top byte lands last.
    always_comb begin
        word_s = buf_r;
        for (int i = 0; i < MAX_BYTES; i++) begin
            if (i == int'(cnt_r) - 1) begin
                word_s[8*i +: 8] = mem_din;
            end else if (i >= int'(nb_r)) begin
                word_s[8*i +: 8] = (sign_r && mem_din[7]) ? 8'hFF : 8'h00;
            end else begin
                word_s[8*i +: 8] = buf_r[8*i +: 8];
            end
        end
    end

    // Bus drive; a stalled read re-addresses the byte still owed so that
    // mem_din is correct again in the first cycle after rdy returns.
    always_comb begin
        mem_a_s    = {ADDR_WIDTH{1'b0}};
        mem_dout_s = 8'h00;
        mem_wr_s   = 1'b0;
        wshift_s   = wdata_r >> {cnt_r, 3'b000};
        if (rst) begin
            mem_wr_s = 1'b0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (ld_go_s) begin
                        mem_a_s = mem_addr;
                    end else if (st_go_s) begin
                        mem_a_s    = mem_addr;
                        mem_dout_s = store_data[7:0];
                        mem_wr_s   = 1'b1;
                    end else if (if_go_s) begin
                        mem_a_s = if_addr;
                    end else begin
                        mem_a_s = {ADDR_WIDTH{1'b0}};
                    end
                end
                S_IF_RD, S_LD_RD: begin
                    if (rdy) begin
                        mem_a_s = addr_r + ADDR_WIDTH'(cnt_r);
                    end else begin
                        mem_a_s = addr_r + ADDR_WIDTH'(cnt_r - NB_ONE);
                    end
                end
                S_ST_WR: begin
                    mem_a_s    = addr_r + ADDR_WIDTH'(cnt_r);
                    mem_dout_s = wshift_s[7:0];
                    mem_wr_s   = rdy;
                end
                default: begin
                    mem_wr_s = 1'b0;
                end
            endcase
        end
    end

    // Transfer sequencing, byte capture and registered completion pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= S_IDLE;
            cnt_r       <= NB_ZERO;
            nb_r        <= NB_ZERO;
            addr_r      <= {ADDR_WIDTH{1'b0}};
            sign_r      <= 1'b0;
            wdata_r     <= {W{1'b0}};
            buf_r       <= {W{1'b0}};
            if_inst_r   <= {W{1'b0}};
            load_data_r <= {W{1'b0}};
            if_done_r   <= 1'b0;
            mem_done_r  <= 1'b0;
        end else if (!rdy) begin
            if_done_r  <= 1'b0;
            mem_done_r <= 1'b0;
        end else begin
            if_done_r  <= 1'b0;
            mem_done_r <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (ld_go_s) begin
                        state_r <= S_LD_RD;
                        cnt_r   <= NB_ONE;
                        addr_r  <= mem_addr;
                        nb_r    <= nb_eff_s;
                        sign_r  <= load_signed;
                    end else if (st_go_s) begin
                        addr_r  <= mem_addr;
                        nb_r    <= nb_eff_s;
                        wdata_r <= store_data;
                        if (nb_eff_s == NB_ONE) begin
                            mem_done_r <= 1'b1;
                        end else begin
                            state_r <= S_ST_WR;
                            cnt_r   <= NB_ONE;
                        end
                    end else if (if_go_s) begin
                        state_r <= S_IF_RD;
                        cnt_r   <= NB_ONE;
                        addr_r  <= if_addr;
                        nb_r    <= NB_MAX;
                        sign_r  <= 1'b0;
                    end
                end
                S_IF_RD: begin
                    if (if_flush) begin
                        state_r <= S_IDLE;
                        cnt_r   <= NB_ZERO;
                    end else begin
                        buf_r <= word_s;
                        if (cnt_r == nb_r) begin
                            state_r   <= S_IDLE;
                            cnt_r     <= NB_ZERO;
                            if_done_r <= 1'b1;
                            if_inst_r <= word_s;
                        end else begin
                            cnt_r <= cnt_r + NB_ONE;
                        end
                    end
                end
                S_LD_RD: begin
                    buf_r <= word_s;
                    if (cnt_r == nb_r) begin
                        state_r     <= S_IDLE;
                        cnt_r       <= NB_ZERO;
                        mem_done_r  <= 1'b1;
                        load_data_r <= word_s;
                    end else begin
                        cnt_r <= cnt_r + NB_ONE;
                    end
                end
                S_ST_WR: begin
                    if (cnt_r == nb_r - NB_ONE) begin
                        state_r    <= S_IDLE;
                        cnt_r      <= NB_ZERO;
                        mem_done_r <= 1'b1;
                    end else begin
                        cnt_r <= cnt_r + NB_ONE;
                    end
                end
                default: begin
                    state_r <= S_IDLE;
                    cnt_r   <= NB_ZERO;
                end
            endcase
        end
    end

    assign if_inst   = if_inst_r;
    assign if_done   = if_done_r;
    assign load_data = load_data_r;
    assign mem_done  = mem_done_r;
    assign mem_a     = mem_a_s;
    assign mem_dout  = mem_dout_s;
    assign mem_wr    = mem_wr_s;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed requests push expected events,
// a negedge monitor pops and compares writes and completion pulses.
module tb_mem_arbiter;

    localparam int K_WR = 0;
    localparam int K_IF = 1;
    localparam int K_LD = 2;
    localparam int K_SD = 3;

    typedef struct {
        int          kind;
        logic [31:0] addr;
        logic [31:0] data;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst, rdy;
    logic [31:0] if_addr, mem_addr, store_data;
    logic        if_request, if_flush, load_req, store_req, load_signed, io_buffer_full;
    logic [2:0]  num_of_bytes;
    logic [7:0]  mem_din;
    logic [31:0] if_inst, load_data, mem_a;
    logic        if_done, mem_done, mem_wr;
    logic [7:0]  mem_dout;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   k;

    mem_arbiter dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .if_addr(if_addr), .if_request(if_request), .if_flush(if_flush),
        .if_inst(if_inst), .if_done(if_done),
        .mem_addr(mem_addr), .load_req(load_req), .store_req(store_req),
        .num_of_bytes(num_of_bytes), .load_signed(load_signed),
        .store_data(store_data), .load_data(load_data), .mem_done(mem_done),
        .io_buffer_full(io_buffer_full), .mem_din(mem_din),
        .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] rom(input logic [31:0] a);
        case (a)
            32'h100: rom = 8'h13;  32'h101: rom = 8'h00;
            32'h102: rom = 8'h00;  32'h103: rom = 8'h00;
            32'h104: rom = 8'h11;  32'h105: rom = 8'h22;
            32'h106: rom = 8'h33;  32'h107: rom = 8'h44;
            32'h108: rom = 8'h01;  32'h109: rom = 8'h02;
            32'h10A: rom = 8'h03;  32'h10B: rom = 8'h04;
            32'h10C: rom = 8'hDE;  32'h10D: rom = 8'hAD;
            32'h10E: rom = 8'hBE;  32'h10F: rom = 8'hEF;
            32'h200: rom = 8'h80;
            32'h204: rom = 8'hCD;  32'h205: rom = 8'hAB;
            32'h300: rom = 8'h01;  32'h301: rom = 8'h02;  32'h302: rom = 8'h83;
            32'hFFFFFFFE: rom = 8'h01;  32'hFFFFFFFF: rom = 8'h02;
            32'h0: rom = 8'h03;    32'h1: rom = 8'h84;
            default: rom = a[7:0] ^ 8'h5A;
        endcase
    endfunction

    // RAM returns the byte addressed in the previous cycle
    always @(posedge clk) mem_din <= rom(mem_a);

    task automatic push(input int kind, input logic [31:0] a, input logic [31:0] d, input int c);
        exp_t e;
        e.kind = kind; e.addr = a; e.data = d; e.cyc = c;
        sb.push_back(e);
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    task automatic sb_check(input int obs, input logic [31:0] a, input logic [31:0] d);
        exp_t e;
        bit   ok;
        total++;
        if (sb.size() == 0) begin
            bad++;
            $display("FAIL unexpected_event kind=%0d cyc=%0d addr=%h data=%h required=none",
                     obs, cyc, a, d);
        end else begin
            e  = sb.pop_front();
            ok = ((obs == e.kind) || (obs == K_LD && e.kind == K_SD)) && (cyc == e.cyc);
            if (e.kind == K_WR) ok = ok && (a == e.addr) && (d[7:0] == e.data[7:0]);
            else if (e.kind != K_SD) ok = ok && (d == e.data);
            if (!ok) begin
                bad++;
                $display("FAIL sb_event actual kind=%0d cyc=%0d addr=%h data=%h required kind=%0d cyc=%0d addr=%h data=%h",
                         obs, cyc, a, d, e.kind, e.cyc, e.addr, e.data);
            end
        end
    endtask

    // Monitor: completion pulses first, then any bus write in the same cycle
    always @(negedge clk) begin
        #2;
        if (!rst) begin
            if (if_done)  sb_check(K_IF, 32'h0, if_inst);
            if (mem_done) sb_check(K_LD, 32'h0, load_data);
            if (mem_wr)   sb_check(K_WR, mem_a, {24'h0, mem_dout});
        end
    end

    task automatic wait_ev(input bit on_if, input int budget);
        int n = 0;
        #1;
        while (!(on_if ? if_done : mem_done) && n < budget) begin
            @(negedge clk); #1; n++;
        end
        if (!(on_if ? if_done : mem_done)) begin
            total++; bad++;
            $display("FAIL wait_done actual=timeout required=done_within_%0d on_if=%0d", budget, on_if);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; rdy = 1'b1; if_addr = 32'h0; if_request = 1'b0; if_flush = 1'b0;
        mem_addr = 32'h55; load_req = 1'b1; store_req = 1'b0; num_of_bytes = 3'd1;
        load_signed = 1'b0; store_data = 32'h0; io_buffer_full = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_mem_a", mem_a, 32'h0);
        chk("rst_mem_wr", 32'(mem_wr), 32'h0);
        chk("rst_mem_dout", 32'(mem_dout), 32'h0);
        chk("rst_if_done", 32'(if_done), 32'h0);
        chk("rst_mem_done", 32'(mem_done), 32'h0);
        chk("rst_if_inst", if_inst, 32'h0);
        chk("rst_load_data", load_data, 32'h0);
        @(negedge clk);
        rst = 1'b0; load_req = 1'b0; mem_addr = 32'h0;
        @(negedge clk);

        // word fetch
        if_addr = 32'h100; if_request = 1'b1; k = cyc;
        push(K_IF, 32'h0, 32'h0000_0013, k + 5);
        for (int i = 0; i < 4; i++) begin
            #1; chk("fetch_addr", mem_a, 32'h100 + 32'(i));
            @(negedge clk);
        end
        wait_ev(1'b1, 10); if_request = 1'b0;
        @(negedge clk);

        // signed byte load wins over a pending fetch; fetch starts in the done cycle
        mem_addr = 32'h200; num_of_bytes = 3'd1; load_signed = 1'b1; load_req = 1'b1;
        if_addr = 32'h104; if_request = 1'b1; k = cyc;
        push(K_LD, 32'h0, 32'hFFFF_FF80, k + 2);
        push(K_IF, 32'h0, 32'h4433_2211, k + 7);
        #1; chk("load_first", mem_a, 32'h200);
        wait_ev(1'b0, 10); load_req = 1'b0;
        #1; chk("if_after_load", mem_a, 32'h104);
        wait_ev(1'b1, 10); if_request = 1'b0;
        @(negedge clk);

        // half-word store
        mem_addr = 32'h40; num_of_bytes = 3'd2; store_data = 32'hAABB_CCDD; store_req = 1'b1; k = cyc;
        push(K_WR, 32'h40, 32'hDD, k);
        push(K_WR, 32'h41, 32'hCC, k + 1);
        push(K_SD, 32'h0, 32'h0, k + 2);
        wait_ev(1'b0, 10); store_req = 1'b0;
        @(negedge clk);

        // IO store stalled for 5 cycles
        io_buffer_full = 1'b1; mem_addr = 32'h0003_0000; num_of_bytes = 3'd1;
        store_data = 32'h0000_005A; store_req = 1'b1; k = cyc;
        push(K_WR, 32'h0003_0000, 32'h5A, k + 5);
        push(K_SD, 32'h0, 32'h0, k + 6);
        repeat (5) @(negedge clk);
        io_buffer_full = 1'b0;
        wait_ev(1'b0, 10); store_req = 1'b0;
        @(negedge clk);

        // flush while the last byte is captured, then a clean fetch
        if_addr = 32'h108; if_request = 1'b1; k = cyc;
        repeat (4) @(negedge clk);
        if_flush = 1'b1; if_request = 1'b0;
        @(negedge clk);
        if_flush = 1'b0; if_addr = 32'h10C; if_request = 1'b1; k = cyc;
        push(K_IF, 32'h0, 32'hEFBE_ADDE, k + 5);
        #1;
        chk("flush_idle_accept", mem_a, 32'h10C);
        chk("flush_inst_hold", if_inst, 32'h4433_2211);
        wait_ev(1'b1, 10); if_request = 1'b0;
        @(negedge clk);

        // 3-byte signed load with rdy low for 3 cycles
        mem_addr = 32'h300; num_of_bytes = 3'd3; load_signed = 1'b1; load_req = 1'b1; k = cyc;
        push(K_LD, 32'h0, 32'hFF83_0201, k + 7);
        repeat (2) @(negedge clk);
        rdy = 1'b0;
        repeat (3) @(negedge clk);
        rdy = 1'b1;
        wait_ev(1'b0, 12); load_req = 1'b0;
        @(negedge clk);

        // unsigned half-word load
        mem_addr = 32'h204; num_of_bytes = 3'd2; load_signed = 1'b0; load_req = 1'b1; k = cyc;
        push(K_LD, 32'h0, 32'h0000_ABCD, k + 3);
        wait_ev(1'b0, 10); load_req = 1'b0;
        @(negedge clk);

        // illegal length 0 acts as full word; address wraps
        mem_addr = 32'hFFFF_FFFE; num_of_bytes = 3'd0; load_signed = 1'b0; load_req = 1'b1; k = cyc;
        push(K_LD, 32'h0, 32'h8403_0201, k + 5);
        repeat (2) @(negedge clk);
        #1; chk("wrap_addr", mem_a, 32'h0);
        wait_ev(1'b0, 10); load_req = 1'b0;
        @(negedge clk);

        // reset in the middle of a word store
        mem_addr = 32'h500; num_of_bytes = 3'd4; store_data = 32'h1122_3344; store_req = 1'b1; k = cyc;
        push(K_WR, 32'h500, 32'h44, k);
        push(K_WR, 32'h501, 32'h33, k + 1);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_st_wr", 32'(mem_wr), 32'h0);
        chk("rst_st_a", mem_a, 32'h0);
        chk("rst_st_dout", 32'(mem_dout), 32'h0);
        @(negedge clk);
        rst = 1'b0; store_req = 1'b0;
        #1;
        chk("post_rst_a", mem_a, 32'h0);
        chk("post_rst_wr", 32'(mem_wr), 32'h0);
        chk("post_rst_mem_done", 32'(mem_done), 32'h0);
        chk("post_rst_if_done", 32'(if_done), 32'h0);
        chk("post_rst_if_inst", if_inst, 32'h0);
        chk("post_rst_load_data", load_data, 32'h0);
        repeat (6) @(negedge clk);

        #3;
        chk("sb_drain", 32'(sb.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
